// File: rtl/aes_pkg.sv
// Shared AES decipher definitions: round counts, key length and FSM
// encodings, and the GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic {
        KEYLEN_128 = 1'b0,
        KEYLEN_256 = 1'b1
    } keylen_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MAIN,
        ST_FINAL
    } state_e;

    function automatic logic [3:0] nr_of(input keylen_e kl);
        return (kl == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
    endfunction

    // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] m;
        p = '0;
        x = a;
        m = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            m = {1'b0, m[7:1]};
        end
        return p;
    endfunction

    // Row r is rotated right by r; byte order is column-major, s(0,0) in the MSB.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],  s[71:64],
                s[95:88],   s[119:112], s[15:8],   s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],  s[103:96]};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box over a full 128-bit state: 16 parallel byte lookups.
module aes_inv_sbox (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = INV_SBOX[data_i[8*i +: 8]];
    end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher: one round per cycle, round keys
// supplied externally for the index presented on `round`.
module aes_decipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         last_round
);

    state_e       state_q, state_d;
    keylen_e      keylen_q, keylen_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] block_q, block_d;
    logic         ready_q, ready_d;
    logic         last_q, last_d;
    logic [127:0] sbox_out;

    // InvShiftRows and InvSubBytes commute, so the permutation is done on the register side.
    aes_inv_sbox u_inv_sbox (
        .data_i (inv_shiftrows(block_q)),
        .data_o (sbox_out)
    );

    assign round      = round_q;
    assign new_block  = block_q;
    assign ready      = ready_q;
    assign last_round = last_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            keylen_q <= KEYLEN_128;
            round_q  <= '0;
            block_q  <= '0;
            ready_q  <= 1'b1;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            keylen_q <= keylen_d;
            round_q  <= round_d;
            block_q  <= block_d;
            ready_q  <= ready_d;
            last_q   <= last_d;
        end
    end

    // Next-state: MAIN exits once the round counter is about to reach zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (next) state_d = ST_INIT;
            ST_INIT:  state_d = ST_MAIN;
            ST_MAIN:  if (round_q == 4'd1) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-state round counter, state update and handshake outputs.
    always_comb begin
        keylen_d = keylen_q;
        round_d  = round_q;
        block_d  = block_q;
        ready_d  = ready_q;
        last_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (next) begin
                    keylen_d = keylen_e'(keylen);
                    round_d  = nr_of(keylen_e'(keylen));
                    ready_d  = 1'b0;
                end
            end
            ST_INIT: begin
                block_d = block ^ round_key;
                round_d = nr_of(keylen_q) - 4'd1;
            end
            ST_MAIN: begin
                block_d = inv_mixcolumns(sbox_out ^ round_key);
                round_d = round_q - 4'd1;
            end
            ST_FINAL: begin
                block_d = sbox_out ^ round_key;
                ready_d = 1'b1;
                last_d  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_decipher_block.sv
module tb_aes_decipher_block;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
    logic         last_round;

    aes_decipher_block dut (
        .clk        (clk),
        .reset      (reset),
        .next       (next),
        .keylen     (keylen),
        .round      (round),
        .round_key  (round_key),
        .block      (block),
        .new_block  (new_block),
        .ready      (ready),
        .last_round (last_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         keylen;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic [127:0] rk_tbl [16];
    logic [127:0] sb_q [$];
    logic [127:0] prev_pt;
    int           n_vec;
    int           n_err;
    vec_t         vecs [5];

    // External key schedule: round key follows the DUT's round index combinationally.
    assign round_key = rk_tbl[round];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, m;
        p = 8'h00; x = a; m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            m = m >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gm(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic void expand_key(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tbl[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endfunction

    // Forward cipher over rk_tbl, used to build extra vectors.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] st;
        st = pt ^ rk_tbl[0];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(st[127 - 8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
                    s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = s[i];
            st = st ^ rk_tbl[r];
        end
        return st;
    endfunction

    // Entered at a negedge with the DUT idle. mode 0: plain, 1: next/keylen noise
    // while busy, 2: reset at busy cycle 5. Returns at the negedge where ready rose.
    task automatic op(input vec_t v, input int mode);
        int           nr, k;
        bit           aborted;
        logic [127:0] exp;
        nr = v.keylen ? 14 : 10;
        expand_key(v.key, v.keylen);
        block  = v.ct;
        keylen = v.keylen;
        next   = 1'b1;
        sb_q.push_back(v.pt);
        @(negedge clk);
        next    = 1'b0;
        k       = 1;
        aborted = 1'b0;
        chk("busy_after_accept", 128'(ready), 128'(0));
        chk("hold_until_init", new_block, prev_pt);
        while (ready !== 1'b1 && k <= 40 && !aborted) begin
            chk("round_seq", 128'(round), 128'(nr + 1 - k));
            chk("no_early_last", 128'(last_round), 128'(0));
            next = 1'b0;
            if (k == 2) block = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 1 && (k == 3 || k == 7)) begin
                next   = 1'b1;
                keylen = ~keylen;
            end
            if (mode == 2 && k == 5) begin
                reset = 1'b1;
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        next = 1'b0;
        if (aborted) begin
            chk("abort_block", new_block, 128'h0);
            chk("abort_round", 128'(round), 128'(0));
            chk("abort_ready", 128'(ready), 128'(1));
            chk("abort_last", 128'(last_round), 128'(0));
            void'(sb_q.pop_back());
            prev_pt = '0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("abort_no_pulse", 128'(last_round), 128'(0));
            end
            return;
        end
        chk("latency", 128'(k - 1), 128'(nr + 1));
        chk("last_pulse", 128'(last_round), 128'(1));
        chk("final_round", 128'(round), 128'(0));
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 128'(1), 128'(0));
        end else begin
            exp = sb_q.pop_front();
            chk("plaintext", new_block, exp);
            prev_pt = exp;
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("last_one_cycle", 128'(last_round), 128'(0));
        chk("idle_ready", 128'(ready), 128'(1));
        chk("idle_round_hold", 128'(round), 128'(0));
        chk("idle_block_hold", new_block, prev_pt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        prev_pt = '0;
        reset   = 1'b1;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        for (int r = 0; r < 16; r++) rk_tbl[r] = '0;

        vecs[0] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h0,
                    {$urandom, $urandom, $urandom, $urandom}};
        vecs[3] = '{1'b1, vecs[1].key, 128'h0, 128'h0};
        vecs[4] = '{1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    128'h0, '1};
        for (int i = 2; i < 5; i++) begin
            expand_key(vecs[i].key, vecs[i].keylen);
            vecs[i].ct = encrypt(vecs[i].pt, vecs[i].keylen ? 14 : 10);
        end

        repeat (2) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_round", 128'(round), 128'(0));
        chk("reset_block", new_block, 128'h0);
        chk("reset_last", 128'(last_round), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            op(vecs[i], 0);
            idle_check();
        end

        op(vecs[0], 1);
        idle_check();

        op(vecs[0], 2);
        op(vecs[0], 0);
        idle_check();

        op(vecs[0], 0);
        op(vecs[1], 0);
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_decipher_block.md
AES_DECIPHER_BLOCK -- requirements
Module: aes_decipher_block

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 next  input  1  single-cycle start request, honoured only in IDLE.
REQ-005 keylen  input  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled with an accepted next.
REQ-006 round  output  4  current round-key index, driven directly from the round counter register.
REQ-007 round_key  input  128  round key for index `round`, valid combinationally in the same cycle.
REQ-008 block  input  128  ciphertext; sampled in the INIT cycle only.
REQ-009 new_block  output  128  state register; holds the plaintext after completion.
REQ-010 ready  output  1  high = idle and result valid; low while deciphering.
REQ-011 last_round  output  1  registered one-cycle pulse marking completion.

Function
REQ-012 FSM states SHALL be IDLE, INIT, MAIN and FINAL.
REQ-013 IDLE, next=1: latch keylen, set round = Nr (10 or 14), clear ready, then go to INIT.
REQ-014 INIT (1 cycle): state = block XOR round_key; round decrements; go to MAIN.
REQ-015 MAIN (Nr-1 cycles, round = Nr-1 down to 1):
- state = InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR round_key);
- round decrements;
- leave for FINAL when the updated round reaches 0.
REQ-016 FINAL (1 cycle, round = 0):
- state = InvSubBytes(InvShiftRows(state)) XOR round_key;
- set ready = 1 and last_round = 1 on the next edge;
- return to IDLE.
REQ-017 Latency: ready SHALL be low for exactly Nr+1 cycles (11 for AES-128, 15 for AES-256) after the edge that samples next.
REQ-018 On completion, new_block SHALL be valid in the same cycle that ready rises.
REQ-019 last_round SHALL be high for exactly that one cycle.
REQ-020 new_block SHALL hold its value until the INIT cycle of the next operation.
REQ-021 next while ready=0 SHALL be ignored; it has no effect on state, round or keylen.
REQ-022 next in the first cycle ready is high SHALL be accepted (back-to-back operation).
REQ-023 A keylen change during an operation SHALL have no effect.
REQ-024 In IDLE, round SHALL hold its last value (0 after completion).
REQ-025 InvSubBytes SHALL be applied to all 16 bytes in parallel within one cycle.
REQ-026 Arithmetic SHALL be GF(2^8) with polynomial 0x11b; InvMixColumns uses multipliers 0e/0b/0d/09.
REQ-027 Byte order SHALL be column-major: bits [127:120] = s(0,0).

Reset
REQ-028 reset=1 SHALL, at the next edge, force: IDLE, new_block = 0, round = 0, ready = 1, last_round = 0, latched keylen = 0.
REQ-029 reset SHALL take priority over next and over any in-flight operation; a reset mid-operation aborts it with no completion pulse.
REQ-030 The first next after reset is released SHALL be accepted normally.

Structure
REQ-031 A shared package aes_pkg SHALL hold:
- round-count constants (10/14);
- keylen encodings;
- FSM state encodings;
- GF multiply, inv_shiftrows and inv_mixcolumns functions.
REQ-032 One combinational sub-module aes_inv_sbox (128-bit in, 128-bit out, 16 lookup tables) SHALL be instantiated once.
REQ-033 No other sub-modules SHALL be used; key expansion stays external.

Verification
REQ-034 FIPS-197 C.1 AES-128: key 000102..0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, next -> after 11 cycles ready=1, last_round pulse, new_block = 00112233445566778899aabbccddeeff; round sequence observed 10,9,...,0.
REQ-035 FIPS-197 C.3 AES-256: key 000102..1f, block 8ea2b7ca516745bfeafc49904b496089 -> after 15 cycles new_block = 00112233445566778899aabbccddeeff; round sequence 14..0.
REQ-036 Busy and keylen handling: next pulsed at cycles 3 and 7 of a C.1 run, with keylen toggled -> same result, same 11-cycle latency, single last_round pulse.
REQ-037 Reset mid-operation: reset asserted at cycle 5 of a C.1 run -> next edge new_block=0, round=0, ready=1, last_round never pulses; a following C.1 run passes.
REQ-038 Back-to-back: next asserted in the cycle ready rises, with a C.3 vector -> C.1 result visible for one cycle, then C.3 completes 15 cycles later with a correct result.
